// File: rtl/wb_pkg.sv
// Shared write-back arbitration types: source encoding, queued entry layout,
// and default data/ROB widths when the build does not supply them.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2,
    WB_SRC_MUL  = 2'd3
  } wb_src_t;

  // One queued result: destination ROB entry plus the value to write.
  typedef struct packed {
    logic [`ROB_ENTRY_WIDTH-1:0] rob_id;
    logic [`WORD_SIZE-1:0]       data;
  } wb_entry_t;

  // Round-robin successor over ALU -> MEM -> MUL -> ALU.
  function automatic wb_src_t wb_src_next(input wb_src_t s);
    case (s)
      WB_SRC_ALU: return WB_SRC_MEM;
      WB_SRC_MEM: return WB_SRC_MUL;
      WB_SRC_MUL: return WB_SRC_ALU;
      default:    return WB_SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-pipe result FIFO. Push is refused while full (no pop-through),
// flush empties the queue at the next edge and drops that cycle's push/pop.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Next-state pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the single ROB result-write port among the ALU, MEM and MUL pipes.
// Each pipe queues {rob_id, data} in its own wb_fifo; one head is granted per
// cycle and drives both the ROB write port and that pipe's WB bypass triplet.
// Build option WB_ARB_RR_EN: round-robin ALU->MEM->MUL instead of the default
// fixed priority MEM > MUL > ALU.
module rob_wb_arbiter
  import wb_pkg::*;
#(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alu_valid,
  input  logic                       mem_valid,
  input  logic                       mul_valid,
  output logic                       alu_ready,
  output logic                       mem_ready,
  output logic                       mul_ready,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_data,
  input  logic [WORD_SIZE-1:0]       mem_data,
  input  logic [WORD_SIZE-1:0]       mul_data,
  output logic                       rob_wr_en,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
  output logic [WORD_SIZE-1:0]       rob_wr_data,
  output wb_src_t                    rob_wr_src,
  output logic                       alu_wb_bypass_enable,
  output logic                       mem_wb_bypass_enable,
  output logic                       mul_wb_bypass_enable,
  output logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
  output logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
  output logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
  output logic [WORD_SIZE-1:0]       alu_wb_data,
  output logic [WORD_SIZE-1:0]       mem_wb_data,
  output logic [WORD_SIZE-1:0]       mul_wb_data
);

  localparam int EW = ROB_ENTRY_WIDTH + WORD_SIZE;

  // Pipe index: bit 0 = ALU, bit 1 = MEM, bit 2 = MUL.
  logic [2:0]    valid_s;
  logic [2:0]    full_s;
  logic [2:0]    empty_s;
  logic [2:0]    gnt_s;
  logic [2:0]    pop_s;
  logic [EW-1:0] din_s  [3];
  logic [EW-1:0] head_s [3];
  wb_src_t       gnt_src_s;
  logic          wr_en_s;

  assign valid_s  = {mul_valid, mem_valid, alu_valid};
  assign din_s[0] = {alu_rob_id, alu_data};
  assign din_s[1] = {mem_rob_id, mem_data};
  assign din_s[2] = {mul_rob_id, mul_data};

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (valid_s[i]),
      .pop   (pop_s[i]),
      .din   (din_s[i]),
      .full  (full_s[i]),
      .empty (empty_s[i]),
      .head  (head_s[i])
    );
  end

  assign alu_ready = !full_s[0];
  assign mem_ready = !full_s[1];
  assign mul_ready = !full_s[2];

`ifdef WB_ARB_RR_EN
  wb_src_t rr_ptr_q;

  // Round-robin grant: first non-empty head searching from rr_ptr_q.
  always_comb begin
    gnt_s = 3'b000;
    case (rr_ptr_q)
      WB_SRC_ALU: begin
        if      (!empty_s[0]) gnt_s = 3'b001;
        else if (!empty_s[1]) gnt_s = 3'b010;
        else if (!empty_s[2]) gnt_s = 3'b100;
        else                  gnt_s = 3'b000;
      end
      WB_SRC_MEM: begin
        if      (!empty_s[1]) gnt_s = 3'b010;
        else if (!empty_s[2]) gnt_s = 3'b100;
        else if (!empty_s[0]) gnt_s = 3'b001;
        else                  gnt_s = 3'b000;
      end
      WB_SRC_MUL: begin
        if      (!empty_s[2]) gnt_s = 3'b100;
        else if (!empty_s[0]) gnt_s = 3'b001;
        else if (!empty_s[1]) gnt_s = 3'b010;
        else                  gnt_s = 3'b000;
      end
      default: gnt_s = 3'b000;
    endcase
  end

  // Advance the round-robin pointer past the grantee; a flushed grant does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= WB_SRC_ALU;
    end else if (wr_en_s) begin
      rr_ptr_q <= wb_src_next(gnt_src_s);
    end else begin
      rr_ptr_q <= rr_ptr_q;
    end
  end
`else
  // Fixed-priority grant: MEM over MUL over ALU.
  always_comb begin
    gnt_s = 3'b000;
    if      (!empty_s[1]) gnt_s = 3'b010;
    else if (!empty_s[2]) gnt_s = 3'b100;
    else if (!empty_s[0]) gnt_s = 3'b001;
    else                  gnt_s = 3'b000;
  end
`endif

  // Encode the one-hot grant as a write-back source.
  always_comb begin
    gnt_src_s = WB_SRC_NONE;
    case (gnt_s)
      3'b001:  gnt_src_s = WB_SRC_ALU;
      3'b010:  gnt_src_s = WB_SRC_MEM;
      3'b100:  gnt_src_s = WB_SRC_MUL;
      default: gnt_src_s = WB_SRC_NONE;
    endcase
  end

  // A flush suppresses both the ROB write and the matching FIFO pop.
  assign wr_en_s = (gnt_s != 3'b000) && !flush;
  assign pop_s   = gnt_s & {3{!flush}};

  // ROB write port: granted head, or all-zero when idle.
  always_comb begin
    rob_wr_en   = wr_en_s;
    rob_wr_src  = WB_SRC_NONE;
    rob_wr_id   = '0;
    rob_wr_data = '0;
    if (wr_en_s) begin
      rob_wr_src = gnt_src_s;
      case (gnt_src_s)
        WB_SRC_ALU: {rob_wr_id, rob_wr_data} = head_s[0];
        WB_SRC_MEM: {rob_wr_id, rob_wr_data} = head_s[1];
        WB_SRC_MUL: {rob_wr_id, rob_wr_data} = head_s[2];
        default: begin
          rob_wr_id   = '0;
          rob_wr_data = '0;
        end
      endcase
    end else begin
      rob_wr_src = WB_SRC_NONE;
    end
  end

  // Bypass triplets: heads always visible, enable only for the pipe being written.
  assign alu_wb_bypass_enable = gnt_s[0] && !flush;
  assign mem_wb_bypass_enable = gnt_s[1] && !flush;
  assign mul_wb_bypass_enable = gnt_s[2] && !flush;
  assign {alu_wb_rob_id, alu_wb_data} = head_s[0];
  assign {mem_wb_rob_id, mem_wb_data} = head_s[1];
  assign {mul_wb_rob_id, mul_wb_data} = head_s[2];

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours WB_ARB_RR_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module tb_rob_wb_arbiter;
  import wb_pkg::*;

  localparam int W  = `WORD_SIZE;
  localparam int RW = `ROB_ENTRY_WIDTH;
  localparam int D  = 2;
  localparam int EW = RW + W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0, mul_valid = 1'b0;
  logic alu_ready, mem_ready, mul_ready;
  logic [RW-1:0] alu_rob_id = '0, mem_rob_id = '0, mul_rob_id = '0;
  logic [W-1:0]  alu_data = '0, mem_data = '0, mul_data = '0;
  logic rob_wr_en;
  logic [RW-1:0] rob_wr_id;
  logic [W-1:0]  rob_wr_data;
  wb_src_t rob_wr_src;
  logic alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable;
  logic [RW-1:0] alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id;
  logic [W-1:0]  alu_wb_data, mem_wb_data, mul_wb_data;

  always #5 clk = ~clk;

  rob_wb_arbiter #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .mem_valid(mem_valid), .mul_valid(mul_valid),
    .alu_ready(alu_ready), .mem_ready(mem_ready), .mul_ready(mul_ready),
    .alu_rob_id(alu_rob_id), .mem_rob_id(mem_rob_id), .mul_rob_id(mul_rob_id),
    .alu_data(alu_data), .mem_data(mem_data), .mul_data(mul_data),
    .rob_wr_en(rob_wr_en), .rob_wr_id(rob_wr_id), .rob_wr_data(rob_wr_data),
    .rob_wr_src(rob_wr_src),
    .alu_wb_bypass_enable(alu_wb_bypass_enable),
    .mem_wb_bypass_enable(mem_wb_bypass_enable),
    .mul_wb_bypass_enable(mul_wb_bypass_enable),
    .alu_wb_rob_id(alu_wb_rob_id), .mem_wb_rob_id(mem_wb_rob_id), .mul_wb_rob_id(mul_wb_rob_id),
    .alu_wb_data(alu_wb_data), .mem_wb_data(mem_wb_data), .mul_wb_data(mul_wb_data)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: one queue per pipe (0=ALU, 1=MEM, 2=MUL) and a RR start index.
  logic [EW-1:0] mq [3][$];
  int rr_m = 0;
  // Log of observed ROB writes.
  int log_src[$];
  int log_id[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
`ifdef WB_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (rr_m + k) % 3;
      if (mq[p].size() > 0) return p;
    end
    return -1;
`else
    if (mq[1].size() > 0) return 1;
    if (mq[2].size() > 0) return 2;
    if (mq[0].size() > 0) return 0;
    return -1;
`endif
  endfunction

  function automatic logic in_valid(input int p);
    case (p)
      0: return alu_valid;
      1: return mem_valid;
      2: return mul_valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [EW-1:0] in_entry(input int p);
    case (p)
      0: return {alu_rob_id, alu_data};
      1: return {mem_rob_id, mem_data};
      2: return {mul_rob_id, mul_data};
      default: return '0;
    endcase
  endfunction

  function automatic logic dut_ready(input int p);
    case (p)
      0: return alu_ready;
      1: return mem_ready;
      2: return mul_ready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic dut_bpe(input int p);
    case (p)
      0: return alu_wb_bypass_enable;
      1: return mem_wb_bypass_enable;
      2: return mul_wb_bypass_enable;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [EW-1:0] dut_bp(input int p);
    case (p)
      0: return {alu_wb_rob_id, alu_wb_data};
      1: return {mem_wb_rob_id, mem_wb_data};
      2: return {mul_wb_rob_id, mul_wb_data};
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    int g;
    bit acc [3];
    g = exp_grant();
    for (int p = 0; p < 3; p++) acc[p] = in_valid(p) && (mq[p].size() < D);
    if (flush) begin
      for (int p = 0; p < 3; p++) mq[p].delete();
    end else begin
      if (g >= 0) begin
        void'(mq[g].pop_front());
        rr_m = (g + 1) % 3;
      end
      for (int p = 0; p < 3; p++) if (acc[p]) mq[p].push_back(in_entry(p));
    end
  endtask

  // Model update at each active edge; asynchronous reset empties it immediately.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) mq[p].delete();
      rr_m = 0;
    end else begin
      model_step();
    end
  end

  task automatic compare_now();
    int g;
    logic en;
    logic [EW-1:0] e;
    g  = exp_grant();
    en = (g >= 0) && !flush;
    e  = en ? mq[g][0] : '0;
    chk("rob_wr_en", rob_wr_en, en);
    chk("rob_wr_src", rob_wr_src, en ? (g + 1) : 0);
    chk("rob_wr_id", rob_wr_id, e[EW-1 -: RW]);
    chk("rob_wr_data", rob_wr_data, e[W-1:0]);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("ready[%0d]", p), dut_ready(p), mq[p].size() < D);
      chk($sformatf("bypass_en[%0d]", p), dut_bpe(p), en && (g == p));
    end
    if (en) chk("bypass_head", dut_bp(g), e);
    if (rob_wr_en === 1'b1) begin
      log_src.push_back(int'(rob_wr_src));
      log_id.push_back(int'(rob_wr_id));
    end
  endtask

  // Single compare process: every mid-cycle against the model.
  initial forever begin
    @(negedge clk);
    compare_now();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    mul_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    log_src.delete();
    log_id.delete();
  endtask

  int exp3 [3];
  int mem_sent[$];
  int next_mem, mem_seen, cnt, n_mul;
  logic acc_mem, saw_mem_low, saw_mul_low, mul_full;

  initial begin
    // 1: reset held with valids high; nothing enqueued.
    rst_n = 1'b0;
    alu_valid = 1'b1; mem_valid = 1'b1; mul_valid = 1'b1;
    alu_rob_id = 5'd7; mem_rob_id = 5'd8; mul_rob_id = 5'd9;
    tick(); tick(); tick();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("reset_alu_ready", alu_ready, 1'b1);
    chk("reset_mem_ready", mem_ready, 1'b1);
    chk("reset_mul_ready", mul_ready, 1'b1);
    chk("reset_wr_en", rob_wr_en, 1'b0);
    tick(); tick();
    chk("reset_no_writes", log_id.size(), 0);

    // 2: single ALU push, written the next cycle, idle after.
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    #1;
    chk("single_wr_en", rob_wr_en, 1'b1);
    chk("single_wr_id", rob_wr_id, 5'd5);
    chk("single_wr_data", rob_wr_data, 32'hDEADBEEF);
    chk("single_wr_src", rob_wr_src, WB_SRC_ALU);
    chk("single_alu_bpe", alu_wb_bypass_enable, 1'b1);
    chk("single_mem_bpe", mem_wb_bypass_enable, 1'b0);
    tick();
    #1;
    chk("single_idle_wr_en", rob_wr_en, 1'b0);
    chk("single_idle_src", rob_wr_src, WB_SRC_NONE);

    // 3: three-way collision.
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rob_id = 5'd2; mem_data = 32'h22;
    mul_valid = 1'b1; mul_rob_id = 5'd3; mul_data = 32'h33;
    tick();
    idle_inputs();
    tick(); tick(); tick(); tick();
`ifdef WB_ARB_RR_EN
    exp3 = '{1, 2, 3};
`else
    exp3 = '{2, 3, 1};
`endif
    chk("collision_count", log_id.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("collision_order[%0d]", i), (log_id.size() > i) ? log_id[i] : -1, exp3[i]);

    // 4: MEM and MUL push every cycle; check backpressure and MEM ordering.
    do_reset();
    next_mem = 10;
    saw_mem_low = 1'b0;
    saw_mul_low = 1'b0;
    mem_sent.delete();
    for (int c = 0; c < 12; c++) begin
      mem_valid = 1'b1; mem_rob_id = RW'(next_mem); mem_data = 32'h1000 + next_mem;
      mul_valid = 1'b1; mul_rob_id = RW'(20 + (c % 10)); mul_data = 32'h2000 + c;
      @(negedge clk);
      acc_mem = mem_ready;
      if (!mem_ready) saw_mem_low = 1'b1;
      if (!mul_ready) saw_mul_low = 1'b1;
      tick();
      if (acc_mem) begin
        mem_sent.push_back(next_mem);
        next_mem++;
      end
    end
    idle_inputs();
    for (int c = 0; c < 30; c++) tick();
`ifdef WB_ARB_RR_EN
    chk("bp_mem_ready_dropped", saw_mem_low, 1'b1);
`else
    chk("bp_mem_ready_dropped", saw_mem_low, 1'b0);
    chk("bp_mul_ready_dropped", saw_mul_low, 1'b1);
`endif
    mem_seen = 0;
    for (int i = 0; i < log_id.size(); i++) begin
      if (log_src[i] == int'(WB_SRC_MEM)) begin
        chk("bp_mem_order", log_id[i], (mem_seen < mem_sent.size()) ? mem_sent[mem_seen] : -1);
        mem_seen++;
      end
    end
    chk("bp_mem_count", mem_seen, mem_sent.size());

    // 5: flush with queued entries and a same-cycle ALU push.
    do_reset();
    alu_valid = 1'b1; alu_rob_id = 5'd1;
    mem_valid = 1'b1; mem_rob_id = 5'd2;
    mul_valid = 1'b1; mul_rob_id = 5'd3;
    tick();
    alu_rob_id = 5'd4; mem_rob_id = 5'd6; mul_rob_id = 5'd7;
    tick();
    mem_valid = 1'b0; mul_valid = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 5'd31;
    flush = 1'b1;
    #1;
    chk("flush_cycle_wr_en", rob_wr_en, 1'b0);
    chk("flush_cycle_bpe", {alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable}, 3'b000);
    tick();
    idle_inputs();
    #1;
    chk("flush_after_wr_en", rob_wr_en, 1'b0);
    chk("flush_after_ready", {alu_ready, mem_ready, mul_ready}, 3'b111);
    for (int c = 0; c < 5; c++) tick();
    cnt = 0;
    for (int i = 0; i < log_id.size(); i++) if (log_id[i] == 31) cnt++;
    chk("flush_dropped_id_written", cnt, 0);

    // 6: asynchronous reset while the MUL FIFO is full.
    do_reset();
    mul_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mem_valid = 1'b1; mem_rob_id = RW'(c); mem_data = 32'h3000 + c;
      mul_valid = 1'b1; mul_rob_id = RW'(20 + c); mul_data = 32'h4000 + c;
      tick();
      #1;
      if (!mul_ready) begin
        mul_full = 1'b1;
        break;
      end
    end
    chk("midreset_mul_full_reached", mul_full, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_mul_ready", mul_ready, 1'b1);
    chk("midreset_wr_en", rob_wr_en, 1'b0);
    chk("midreset_mul_bpe", mul_wb_bypass_enable, 1'b0);
    idle_inputs();
    log_src.delete();
    log_id.delete();
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    n_mul = 0;
    for (int i = 0; i < log_src.size(); i++) if (log_src[i] == int'(WB_SRC_MUL)) n_mul++;
    chk("midreset_no_stale_mul", n_mul, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
